// File: rtl/xbar_bank_arbiter_if.sv
// Request/grant bundle between the channel buffer heads and one bank arbiter.
// The master side drives channel requests and bank ready; the slave side is the arbiter.
interface xbar_bank_arb_if #(
   parameter int NUM_CH = 3
) ();
   logic [NUM_CH-1:0] ch_req_valid;
   logic [NUM_CH-1:0] ch_pop;
   logic              bank_req_valid;
   logic              bank_req_ready;
   logic [NUM_CH-1:0] bank_ch_1hot_id;
   logic              arb_locked;

   modport master (
      output ch_req_valid,
      output bank_req_ready,
      input  ch_pop,
      input  bank_req_valid,
      input  bank_ch_1hot_id,
      input  arb_locked
   );

   modport slave (
      input  ch_req_valid,
      input  bank_req_ready,
      output ch_pop,
      output bank_req_valid,
      output bank_ch_1hot_id,
      output arb_locked
   );
endinterface

// File: rtl/xbar_bank_arbiter.sv
// Per-bank round-robin arbiter with zero-latency grant and grant lock under back-pressure.
// Optional starvation guard enabled by defining XBAR_ARB_STARVE_GUARD_EN.
//
// state    | meaning
// ST_OPEN  | no grant held; winner chosen fresh each cycle
// ST_HOLD  | bank stalled last cycle; grant_q is held until it fires
module xbar_bank_arbiter #(
   parameter int NUM_CH       = 3,
   parameter int STARVE_LIMIT = 15,
   parameter int CNT_W        = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   xbar_bank_arb_if.slave     bus
);
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   if ((2 ** CNT_W) <= STARVE_LIMIT) begin : g_cnt_w_check
      $error("CNT_W too narrow for STARVE_LIMIT");
   end

   typedef enum logic {ST_OPEN, ST_HOLD} state_t;

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] rr_grant;
   logic [NUM_CH-1:0] pick;
   logic [NUM_CH-1:0] grant;
   logic [NUM_CH-1:0] pop;
   logic [PTR_W-1:0]  win_idx;
   logic              any_req;
   logic              lock_eff;
   logic              fire;

   assign req     = bus.ch_req_valid;
   assign any_req = rst_n & (|req);
   // A held grant whose requester vanished is abandoned in the same cycle.
   assign lock_eff = rst_n & (state_q == ST_HOLD) & (|(grant_q & req));

   always_comb begin
      int  idx;
      logic found;
      rr_grant = '0;
      found    = 1'b0;
      for (int off = 0; off < NUM_CH; off++) begin
         idx = (int'(rr_ptr_q) + off) % NUM_CH;
         if (!found && req[idx]) begin
            rr_grant[idx] = 1'b1;
            found         = 1'b1;
         end
      end
   end

`ifdef XBAR_ARB_STARVE_GUARD_EN
   logic [CNT_W-1:0]  wait_q [NUM_CH];
   logic [CNT_W-1:0]  wait_d [NUM_CH];
   logic [NUM_CH-1:0] starved;
   logic [NUM_CH-1:0] starve_grant;

   always_comb begin
      logic found;
      starve_grant = '0;
      found        = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         starved[i] = req[i] && (wait_q[i] == CNT_W'(STARVE_LIMIT));
         if (!found && starved[i]) begin
            starve_grant[i] = 1'b1;
            found           = 1'b1;
         end
      end
      pick = (|starved) ? starve_grant : rr_grant;
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (req[i] && !pop[i]) begin
            wait_d[i] = (wait_q[i] == CNT_W'(STARVE_LIMIT)) ? wait_q[i] : wait_q[i] + 1'b1;
         end else begin
            wait_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) wait_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) wait_q[i] <= wait_d[i];
      end
   end
`else
   assign pick = rr_grant;
`endif

   always_comb begin
      grant = '0;
      if (lock_eff) begin
         grant = grant_q;
      end else if (any_req) begin
         grant = pick;
      end
   end

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) win_idx = PTR_W'(i);
      end
   end

   assign fire = any_req & bus.bank_req_ready;
   assign pop  = fire ? grant : '0;

   always_comb begin
      state_d  = ST_OPEN;
      grant_d  = '0;
      rr_ptr_d = rr_ptr_q;
      if (fire) begin
         rr_ptr_d = (win_idx == PTR_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
      end else if (any_req) begin
         state_d = ST_HOLD;
         grant_d = grant;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_OPEN;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.ch_pop          = pop;
   assign bus.bank_req_valid  = any_req;
   assign bus.bank_ch_1hot_id = grant;
   assign bus.arb_locked      = lock_eff;
endmodule

// File: tb/tb_xbar_bank_arbiter.sv
// Directed bench for xbar_bank_arbiter: reset, round-robin, lock, async reset mid-stall, starvation.
module tb_xbar_bank_arbiter;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   xbar_bank_arb_if #(.NUM_CH(3)) bus ();

   xbar_bank_arbiter #(.NUM_CH(3), .STARVE_LIMIT(4), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global invariants on every sampled cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         n_cmp++;
         if (!$onehot0(bus.ch_pop) ||
             ((bus.ch_pop != 3'b000) && !bus.bank_req_ready) ||
             ((bus.bank_req_valid && bus.bank_req_ready) && (bus.bank_ch_1hot_id !== bus.ch_pop))) begin
            $display("FAIL invariant: pop=%b id=%b ready=%b valid=%b", bus.ch_pop,
                     bus.bank_ch_1hot_id, bus.bank_req_ready, bus.bank_req_valid);
            n_bad++;
         end
      end
   end

   // Stimulus must hold a stalled request until it is popped.
   logic       stall_last;
   logic [2:0] id_last;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_last = 1'b0;
         id_last    = 3'b000;
      end else begin
         if (stall_last && ((bus.ch_req_valid & id_last) == 3'b000))
            $error("stimulus dropped a locked request");
         stall_last = bus.bank_req_valid & ~bus.bank_req_ready;
         id_last    = bus.bank_ch_1hot_id;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.ch_req_valid   = 3'b000;
      bus.bank_req_ready = 1'b0;
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.ch_req_valid   = 3'b111;
      bus.bank_req_ready = 1'b1;
      #2;
      n_cmp++; if (bus.bank_req_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", bus.bank_req_valid); n_bad++; end
      n_cmp++; if (bus.bank_ch_1hot_id !== 3'b000) begin $display("FAIL rst_id: got %b want 000", bus.bank_ch_1hot_id); n_bad++; end
      n_cmp++; if (bus.ch_pop !== 3'b000) begin $display("FAIL rst_pop: got %b want 000", bus.ch_pop); n_bad++; end
      n_cmp++; if (bus.arb_locked !== 1'b0) begin $display("FAIL rst_locked: got %b want 0", bus.arb_locked); n_bad++; end
      next_cycle();
      rst_n = 1'b1;
      #2;
      n_cmp++; if (bus.bank_ch_1hot_id !== 3'b001) begin $display("FAIL rel_id: got %b want 001", bus.bank_ch_1hot_id); n_bad++; end
      n_cmp++; if (bus.ch_pop !== 3'b001) begin $display("FAIL rel_pop: got %b want 001", bus.ch_pop); n_bad++; end
      next_cycle();
   endtask

   task automatic test_rr_fairness();
      logic [2:0] exp_pop [6];
      exp_pop = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      do_reset();
      bus.ch_req_valid   = 3'b111;
      bus.bank_req_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #2;
         n_cmp++;
         if (bus.ch_pop !== exp_pop[k]) begin
            $display("FAIL rr_pop[%0d]: got %b want %b", k, bus.ch_pop, exp_pop[k]);
            n_bad++;
         end
         next_cycle();
      end
   endtask

   task automatic test_lock();
      do_reset();
      bus.ch_req_valid   = 3'b011;
      bus.bank_req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2;
         n_cmp++; if (bus.bank_ch_1hot_id !== 3'b001) begin $display("FAIL lock_id[%0d]: got %b want 001", k, bus.bank_ch_1hot_id); n_bad++; end
         n_cmp++; if (bus.ch_pop !== 3'b000) begin $display("FAIL lock_pop[%0d]: got %b want 000", k, bus.ch_pop); n_bad++; end
         n_cmp++; if (bus.arb_locked !== (k > 0)) begin $display("FAIL lock_flag[%0d]: got %b want %b", k, bus.arb_locked, (k > 0)); n_bad++; end
         next_cycle();
      end
      bus.ch_req_valid = 3'b111;
      #2;
      n_cmp++; if (bus.bank_ch_1hot_id !== 3'b001) begin $display("FAIL lock_raise_id: got %b want 001", bus.bank_ch_1hot_id); n_bad++; end
      n_cmp++; if (bus.arb_locked !== 1'b1) begin $display("FAIL lock_raise_flag: got %b want 1", bus.arb_locked); n_bad++; end
      next_cycle();
      bus.bank_req_ready = 1'b1;
      #2;
      n_cmp++; if (bus.ch_pop !== 3'b001) begin $display("FAIL lock_release_pop: got %b want 001", bus.ch_pop); n_bad++; end
      next_cycle();
      #2;
      n_cmp++; if (bus.ch_pop !== 3'b010) begin $display("FAIL lock_next_pop: got %b want 010", bus.ch_pop); n_bad++; end
      next_cycle();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      bus.ch_req_valid   = 3'b011;
      bus.bank_req_ready = 1'b1;
      next_cycle();
      next_cycle();
      bus.ch_req_valid   = 3'b111;
      bus.bank_req_ready = 1'b0;
      next_cycle();
      #2;
      n_cmp++; if (bus.bank_ch_1hot_id !== 3'b100) begin $display("FAIL ms_lock_id: got %b want 100", bus.bank_ch_1hot_id); n_bad++; end
      n_cmp++; if (bus.arb_locked !== 1'b1) begin $display("FAIL ms_lock_flag: got %b want 1", bus.arb_locked); n_bad++; end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.bank_req_valid !== 1'b0) begin $display("FAIL ms_async_valid: got %b want 0", bus.bank_req_valid); n_bad++; end
      n_cmp++; if (bus.bank_ch_1hot_id !== 3'b000) begin $display("FAIL ms_async_id: got %b want 000", bus.bank_ch_1hot_id); n_bad++; end
      n_cmp++; if (bus.arb_locked !== 1'b0) begin $display("FAIL ms_async_flag: got %b want 0", bus.arb_locked); n_bad++; end
      next_cycle();
      rst_n = 1'b1;
      bus.ch_req_valid   = 3'b110;
      bus.bank_req_ready = 1'b1;
      #2;
      n_cmp++; if (bus.bank_ch_1hot_id !== 3'b010) begin $display("FAIL ms_after_id: got %b want 010", bus.bank_ch_1hot_id); n_bad++; end
      n_cmp++; if (bus.ch_pop !== 3'b010) begin $display("FAIL ms_after_pop: got %b want 010", bus.ch_pop); n_bad++; end
      next_cycle();
   endtask

   // ch0 waits while the bank stalls on ch1; after ch1 pops rr points at ch2.
   task automatic test_starve();
      logic [2:0] exp_f;
      logic [2:0] exp_g;
`ifdef XBAR_ARB_STARVE_GUARD_EN
      exp_f = 3'b001;
      exp_g = 3'b010;
`else
      exp_f = 3'b100;
      exp_g = 3'b001;
`endif
      do_reset();
      bus.ch_req_valid   = 3'b001;
      bus.bank_req_ready = 1'b1;
      next_cycle();
      bus.ch_req_valid   = 3'b011;
      bus.bank_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #2;
         n_cmp++; if (bus.bank_ch_1hot_id !== 3'b010) begin $display("FAIL st_stall_id[%0d]: got %b want 010", k, bus.bank_ch_1hot_id); n_bad++; end
         next_cycle();
      end
      bus.ch_req_valid   = 3'b111;
      bus.bank_req_ready = 1'b1;
      #2;
      n_cmp++; if (bus.ch_pop !== 3'b010) begin $display("FAIL st_release_pop: got %b want 010", bus.ch_pop); n_bad++; end
      next_cycle();
      #2;
      n_cmp++; if (bus.ch_pop !== exp_f) begin $display("FAIL st_first_pop: got %b want %b", bus.ch_pop, exp_f); n_bad++; end
      next_cycle();
      #2;
      n_cmp++; if (bus.ch_pop !== exp_g) begin $display("FAIL st_second_pop: got %b want %b", bus.ch_pop, exp_g); n_bad++; end
      next_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.ch_req_valid   = 3'b000;
      bus.bank_req_ready = 1'b0;
      next_cycle();
      test_reset();
      test_rr_fairness();
      test_lock();
      test_reset_mid_stall();
      test_starve();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
